// File: rtl/mem2_stage.sv
// -----------------------------------------------------------------------------
// mem2_stage
//   Second memory pipeline stage, directly downstream of MEM. Latches the
//   instruction leaving MEM, waits for the DCache load response, aligns and
//   extends the load data (LB/LBU/LH/LHU/LW/LWL/LWR) and presents the final
//   result to WB and to the EXE bypass network. While a load response is
//   outstanding the stage raises MEM2_Stall to hold MEM and earlier stages.
//
// Parameters
//   PC_RST          value loaded into MEM2_PC on reset or flush
//
// Ports
//   clk             in   1   core clock
//   rst             in   1   asynchronous reset, active-high
//   MEM2_Flush      in   1   squash MEM2 contents (exception/redirect)
//   MEM2_Wr         in   1   pipeline register load enable (0 = upstream holds)
//   MEM_PC          in   32  PC of instruction leaving MEM
//   MEM_ALUOut      in   32  effective address or ALU result
//   MEM_OutB        in   32  rt/HILO/CP0 value (LWL/LWR merge source, WbSel result)
//   MEM_Dst         in   5   destination GPR
//   MEM_RegWr       in   1   GPR write enable after exception masking
//   MEM_WbSel       in   1   1 = result is OutB, 0 = ALUOut (non-load)
//   MEM_IsLoad      in   1   instruction is a load (DCache request already issued)
//   MEM_LoadCode    in   3   0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR
//   dc_rvalid       in   1   DCache read data valid (one pulse per request)
//   dc_rdata        in   32  DCache read word (word-aligned)
//   MEM2_PC         out  32  registered PC
//   MEM2_Dst        out  5   registered destination
//   MEM2_RegWr      out  1   write enable to WB (0 while result not ready)
//   MEM2_Result     out  32  final aligned/extended result
//   MEM2_ResultRdy  out  1   MEM2_Result valid for bypass
//   MEM2_Stall      out  1   load outstanding; hold MEM and earlier stages
// -----------------------------------------------------------------------------
module mem2_stage #(
    parameter logic [31:0] PC_RST = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM2_Flush,
    input  logic        MEM2_Wr,
    input  logic [31:0] MEM_PC,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_OutB,
    input  logic [4:0]  MEM_Dst,
    input  logic        MEM_RegWr,
    input  logic        MEM_WbSel,
    input  logic        MEM_IsLoad,
    input  logic [2:0]  MEM_LoadCode,
    input  logic        dc_rvalid,
    input  logic [31:0] dc_rdata,
    output logic [31:0] MEM2_PC,
    output logic [4:0]  MEM2_Dst,
    output logic        MEM2_RegWr,
    output logic [31:0] MEM2_Result,
    output logic        MEM2_ResultRdy,
    output logic        MEM2_Stall
);

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [2:0] LD_LWL = 3'd5;
    localparam logic [2:0] LD_LWR = 3'd6;

    // StWait:  load latched, response not yet returned.
    // StHold:  response captured in rbuf_q, result valid until the register advances.
    // StDrain: load squashed while its response is still in flight; swallow it.
    typedef enum logic [1:0] {StIdle, StWait, StHold, StDrain} state_e;

    state_e      state_q, state_d;

    logic [31:0] pc_q;
    logic [31:0] alu_q;
    logic [31:0] outb_q;
    logic [4:0]  dst_q;
    logic        regwr_q;
    logic        wbsel_q;
    logic        isload_q;
    logic [2:0]  code_q;
    logic [31:0] rbuf_q;

    logic        stall;
    logic        result_rdy;
    logic        adv;
    logic        load_in;
    logic [31:0] load_result;

    // -------------------------------------------------------------------------
    // Pipeline register
    // -------------------------------------------------------------------------
    assign adv     = MEM2_Wr & ~stall;
    // A load only enters when the register actually advances and is not squashed.
    assign load_in = adv & ~MEM2_Flush & MEM_IsLoad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= PC_RST;
            alu_q    <= '0;
            outb_q   <= '0;
            dst_q    <= '0;
            regwr_q  <= 1'b0;
            wbsel_q  <= 1'b0;
            isload_q <= 1'b0;
            code_q   <= '0;
        end else if (MEM2_Flush) begin
            // Flush wins over Wr and applies even while stalled.
            pc_q     <= PC_RST;
            regwr_q  <= 1'b0;
            isload_q <= 1'b0;
        end else if (adv) begin
            pc_q     <= MEM_PC;
            alu_q    <= MEM_ALUOut;
            outb_q   <= MEM_OutB;
            dst_q    <= MEM_Dst;
            regwr_q  <= MEM_RegWr;
            wbsel_q  <= MEM_WbSel;
            isload_q <= MEM_IsLoad;
            code_q   <= MEM_LoadCode;
        end
    end

    // -------------------------------------------------------------------------
    // Response buffer: only a response for the load we are waiting on is kept.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbuf_q <= '0;
        end else if (state_q == StWait && dc_rvalid) begin
            rbuf_q <= dc_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (load_in) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (MEM2_Flush) begin
                    // A response arriving with the flush is already consumed.
                    state_d = dc_rvalid ? StIdle : StDrain;
                end else if (dc_rvalid) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (MEM2_Flush) begin
                    state_d = StIdle;
                end else if (adv) begin
                    state_d = load_in ? StWait : StIdle;
                end
            end
            StDrain: begin
                if (dc_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        result_rdy = 1'b1;
        if (state_q == StWait || state_q == StDrain) begin
            stall      = 1'b1;
            result_rdy = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Load alignment / extension (data always comes from rbuf_q in StHold)
    // -------------------------------------------------------------------------
    always_comb begin
        logic [31:0] d;
        logic [31:0] r;
        logic [1:0]  a;
        logic [7:0]  b;
        logic [15:0] h;

        d = rbuf_q;
        r = outb_q;
        a = alu_q[1:0];

        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase

        // a[0] is ignored for halfwords; misalignment traps upstream.
        h = a[1] ? d[31:16] : d[15:0];

        load_result = d;
        case (code_q)
            LD_LW:  load_result = d;
            LD_LB:  load_result = {{24{b[7]}}, b};
            LD_LBU: load_result = {24'd0, b};
            LD_LH:  load_result = {{16{h[15]}}, h};
            LD_LHU: load_result = {16'd0, h};
            LD_LWL: begin
                case (a)
                    2'd0:    load_result = {d[7:0],  r[23:0]};
                    2'd1:    load_result = {d[15:0], r[15:0]};
                    2'd2:    load_result = {d[23:0], r[7:0]};
                    default: load_result = d;
                endcase
            end
            LD_LWR: begin
                case (a)
                    2'd0:    load_result = d;
                    2'd1:    load_result = {r[31:24], d[31:8]};
                    2'd2:    load_result = {r[31:16], d[31:16]};
                    default: load_result = {r[31:8],  d[31:24]};
                endcase
            end
            default: load_result = d;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign MEM2_PC        = pc_q;
    assign MEM2_Dst       = dst_q;
    assign MEM2_Stall     = stall;
    assign MEM2_ResultRdy = result_rdy;
    // A waiting load must never reach the register file.
    assign MEM2_RegWr     = regwr_q & result_rdy;
    assign MEM2_Result    = isload_q ? load_result : (wbsel_q ? outb_q : alu_q);

`ifndef SYNTHESIS
    // The DCache only answers requests we are waiting on or draining.
    rvalid_only_when_expected : assert property (
        @(posedge clk) disable iff (rst)
        dc_rvalid |-> (state_q == StWait || state_q == StDrain)
    );
`endif

endmodule
